// File: rtl/neuron_mac.sv
// Fixed-point neuron: LANES-wide multiply-accumulate over INPUT_SIZE pairs,
// then floor-shift, bias, optional ReLU and saturation to DATA_W.
module neuron_mac #(
  parameter int INPUT_SIZE = 16,
  parameter int DATA_W     = 16,
  parameter int LANES      = 4,
  parameter int FRAC_BITS  = 8
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic signed [DATA_W-1:0] inputs  [INPUT_SIZE],
  input  logic signed [DATA_W-1:0] weights [INPUT_SIZE],
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] result,
  output logic                     busy,
  output logic                     done,
  output logic                     sat
);

  localparam int ACC_W  = 2*DATA_W + $clog2(INPUT_SIZE) + 1;
  localparam int BEATS  = (INPUT_SIZE + LANES - 1) / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, FINISH} state_t;

  state_t                   state_q;
  logic [BEAT_W-1:0]        beat_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] result_q;
  logic                     busy_q, done_q, sat_q;

  logic signed [DATA_W-1:0] x_q [INPUT_SIZE];
  logic signed [DATA_W-1:0] w_q [INPUT_SIZE];
  logic signed [DATA_W-1:0] bias_q;
  logic                     relu_q;

  // Operands are pure datapath: loaded only on an accepted start, no reset needed.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      x_q    <= inputs;
      w_q    <= weights;
      bias_q <= bias;
      relu_q <= relu_en;
    end
  end

  logic signed [DATA_W-1:0]   cand_x    [LANES][BEATS];
  logic signed [DATA_W-1:0]   cand_w    [LANES][BEATS];
  logic signed [2*DATA_W-1:0] lane_prod [LANES];

  // Lane gi of beat gb reads pair gb*LANES+gi; slots past the last pair read zero.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      for (genvar gb = 0; gb < BEATS; gb++) begin : g_beat
        if (gb*LANES + gi < INPUT_SIZE) begin : g_real
          assign cand_x[gi][gb] = x_q[gb*LANES + gi];
          assign cand_w[gi][gb] = w_q[gb*LANES + gi];
        end else begin : g_pad
          assign cand_x[gi][gb] = '0;
          assign cand_w[gi][gb] = '0;
        end
      end

      logic signed [DATA_W-1:0] op_x, op_w;
      always_comb begin
        op_x = '0;
        op_w = '0;
        for (int b = 0; b < BEATS; b++) begin
          if (beat_q == BEAT_W'(b)) begin
            op_x = cand_x[gi][b];
            op_w = cand_w[gi][b];
          end
        end
      end
      assign lane_prod[gi] = (2*DATA_W)'(op_x) * (2*DATA_W)'(op_w);
    end
  endgenerate

  logic signed [ACC_W-1:0] beat_sum;
  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_sum = beat_sum + ACC_W'(lane_prod[l]);
    end
  end

  logic signed [ACC_W:0]    shifted, fin_s;
  logic signed [DATA_W-1:0] fin_val;
  logic                     fin_sat;
  always_comb begin
    shifted = (ACC_W+1)'(acc_q >>> FRAC_BITS);
    fin_s   = shifted + (ACC_W+1)'(bias_q);
    if (relu_q && fin_s < 0) begin
      fin_s = '0;
    end
    fin_val = fin_s[DATA_W-1:0];
    fin_sat = 1'b0;
    if (fin_s > MAX_V) begin
      fin_val = {1'b0, {(DATA_W-1){1'b1}}};
      fin_sat = 1'b1;
    end else if (fin_s < MIN_V) begin
      fin_val = {1'b1, {(DATA_W-1){1'b0}}};
      fin_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_q + beat_sum;
          if (beat_q == LAST_BEAT) begin
            state_q <= FINISH;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        FINISH: begin
          result_q <= fin_val;
          sat_q    <= fin_sat;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sat    = sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: default 16/4 instance plus a 10-pair
// instance whose last beat is only partly populated.
module tb_neuron_mac;
  localparam int N = 16, DW = 16, L = 4, FB = 8, BEATS = 4;
  localparam int N2 = 10, BEATS2 = 3;

  logic clk = 1'b0, rstN = 1'b0, start = 1'b0, relu_en = 1'b0;
  logic signed [DW-1:0] inputs [N];
  logic signed [DW-1:0] weights [N];
  logic signed [DW-1:0] bias;
  logic signed [DW-1:0] result;
  logic busy, done, sat;

  logic start2 = 1'b0, relu2 = 1'b0;
  logic signed [DW-1:0] in2 [N2];
  logic signed [DW-1:0] w2 [N2];
  logic signed [DW-1:0] bias2;
  logic signed [DW-1:0] result2;
  logic busy2, done2, sat2;

  neuron_mac #(.INPUT_SIZE(N), .DATA_W(DW), .LANES(L), .FRAC_BITS(FB)) dut (
    .clk(clk), .rstN(rstN), .start(start), .relu_en(relu_en),
    .inputs(inputs), .weights(weights), .bias(bias),
    .result(result), .busy(busy), .done(done), .sat(sat));

  neuron_mac #(.INPUT_SIZE(N2), .DATA_W(DW), .LANES(4), .FRAC_BITS(FB)) u_rem (
    .clk(clk), .rstN(rstN), .start(start2), .relu_en(relu2),
    .inputs(in2), .weights(w2), .bias(bias2),
    .result(result2), .busy(busy2), .done(done2), .sat(sat2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  typedef struct {
    int res;
    bit sat;
    int due;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: exact integer dot product, floor shift, bias, ReLU, clamp.
  function automatic exp_t model(input int x[N], input int w[N], input int n,
                                 input int b, input bit relu);
    longint acc = 0;
    longint s;
    exp_t e;
    for (int i = 0; i < n; i++) acc += longint'(x[i]) * longint'(w[i]);
    s = (acc >>> FB) + longint'(b);
    if (relu && s < 0) s = 0;
    e.sat = 1'b0;
    if (s > 32767) begin
      s = 32767; e.sat = 1'b1;
    end else if (s < -32768) begin
      s = -32768; e.sat = 1'b1;
    end
    e.res = int'(s);
    e.due = 0;
    return e;
  endfunction

  function automatic int rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return int'(t);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstN && done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1, expected no pending operation (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("result", int'(result), e.res);
        check("sat", int'(sat), int'(e.sat));
        check("done_latency", cyc, e.due);
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  // Called at a negedge; leaves the bench at the negedge where done is seen.
  task automatic run_op(input int x[N], input int w[N], input int b,
                        input bit relu, input bit noise);
    exp_t e;
    bit seen;
    e = model(x, w, N, b, relu);
    e.due = cyc + BEATS + 2;
    for (int i = 0; i < N; i++) begin
      inputs[i]  = DW'(x[i]);
      weights[i] = DW'(w[i]);
    end
    bias    = DW'(b);
    relu_en = relu;
    start   = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    if (noise) begin
      for (int i = 0; i < N; i++) begin
        inputs[i]  = DW'(rnd16());
        weights[i] = DW'(rnd16());
      end
      bias    = DW'(rnd16());
      relu_en = 1'($urandom_range(0, 1));
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (noise) start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done within 20 cycles, expected done");
      exp_q.delete();
    end
  endtask

  task automatic run_rem(input int x[N], input int w[N], input int b, input bit relu);
    exp_t e;
    bit seen;
    e = model(x, w, N2, b, relu);
    e.due = cyc + BEATS2 + 2;
    for (int i = 0; i < N2; i++) begin
      in2[i] = DW'(x[i]);
      w2[i]  = DW'(w[i]);
    end
    bias2  = DW'(b);
    relu2  = relu;
    start2 = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL rem_timeout: got no done within 20 cycles, expected done");
    end else begin
      check("rem_result", int'(result2), e.res);
      check("rem_sat", int'(sat2), int'(e.sat));
      check("rem_latency", cyc, e.due);
      check("rem_busy_at_done", int'(busy2), 0);
    end
  endtask

  int xv[N], wv[N];

  task automatic fill(input int xval, input int wval);
    for (int i = 0; i < N; i++) begin
      xv[i] = xval;
      wv[i] = wval;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      inputs[i] = '0;
      weights[i] = '0;
    end
    for (int i = 0; i < N2; i++) begin
      in2[i] = '0;
      w2[i] = '0;
    end
    bias = '0;
    bias2 = '0;

    @(negedge clk);
    @(negedge clk);
    check("reset_result", int'(result), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_sat", int'(sat), 0);
    rstN = 1'b1;

    // Directed cases, all back-to-back; the first start lands on the first edge after reset.
    fill(256, 256);       run_op(xv, wv, 0, 1'b0, 1'b0);
    fill(32767, 32767);   run_op(xv, wv, 0, 1'b0, 1'b1);
    fill(-32768, 32767);  run_op(xv, wv, 0, 1'b0, 1'b1);
    fill(-256, 256);      run_op(xv, wv, 0, 1'b0, 1'b0);
    fill(-256, 256);      run_op(xv, wv, 0, 1'b1, 1'b1);
    fill(0, 0); xv[0] = -1; wv[0] = 1;
    run_op(xv, wv, 0, 1'b0, 1'b0);
    run_op(xv, wv, 5, 1'b0, 1'b1);

    for (int t = 0; t < 40; t++) begin
      bit full;
      full = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        xv[i] = full ? rnd16() : int'($urandom_range(0, 4000)) - 2000;
        wv[i] = full ? rnd16() : int'($urandom_range(0, 4000)) - 2000;
      end
      run_op(xv, wv, rnd16(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Abort mid-operation: outputs clear at once and no done follows.
    fill(256, 256);
    run_op(xv, wv, 0, 1'b0, 1'b0);
    check("pre_abort_result", int'(result), 4096);
    for (int i = 0; i < N; i++) begin
      inputs[i] = DW'(1000);
      weights[i] = DW'(1000);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rstN = 1'b0;
    #1;
    check("abort_result", int'(result), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_sat", int'(sat), 0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    fill(-256, 256);
    run_op(xv, wv, 100, 1'b0, 1'b0);
    repeat (8) @(negedge clk);

    fill(256, 256);
    run_rem(xv, wv, 0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) begin
        xv[i] = rnd16();
        wv[i] = rnd16();
      end
      run_rem(xv, wv, rnd16(), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 16, number of input/weight pairs (>=1).
REQ-002 SHALL have parameter DATA_W, default 16, signed width of inputs, weights, bias and result.
REQ-003 SHALL have parameter LANES, default 4, multiply-accumulates per cycle (1..INPUT_SIZE).
REQ-004 SHALL have parameter FRAC_BITS, default 8, arithmetic right shift applied to the accumulator (0..2*DATA_W-1).
REQ-005 SHALL derive localparam ACC_W = 2*DATA_W + clog2(INPUT_SIZE) + 1 and BEATS = ceil(INPUT_SIZE/LANES).
REQ-006 SHALL have port clk, input, 1, single clock, rising edge.
REQ-007 SHALL have port rstN, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port start, input, 1, request a new dot product.
REQ-009 SHALL have port relu_en, input, 1, 1 = clamp negative results to 0.
REQ-010 SHALL have port inputs, input, array [INPUT_SIZE] x DATA_W signed, activations.
REQ-011 SHALL have port weights, input, array [INPUT_SIZE] x DATA_W signed.
REQ-012 SHALL have port bias, input, DATA_W signed.
REQ-013 SHALL have port result, output, DATA_W signed, registered output value.
REQ-014 SHALL have port busy, output, 1, high while not IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when result updates.
REQ-016 SHALL have port sat, output, 1, high with done when result was clipped to the DATA_W range.

Function
REQ-017 SHALL implement states IDLE, MAC and FINISH.
REQ-018 In IDLE, start=1 SHALL register inputs, weights, bias and relu_en, clear the accumulator and beat counter, and enter MAC.
REQ-019 start SHALL be ignored while busy=1; captured operands SHALL NOT change until the next accepted start.
REQ-020 Each MAC cycle SHALL add the LANES products of beat k (indices k*LANES .. k*LANES+LANES-1) to the ACC_W-bit accumulator, sign-extended.
REQ-021 Lanes with index >= INPUT_SIZE in the last beat SHALL contribute zero.
REQ-022 After BEATS MAC cycles, the FSM SHALL enter FINISH.
REQ-023 FINISH SHALL compute s = (acc >>> FRAC_BITS) + sign-extended bias, rounding toward negative infinity.
REQ-024 FINISH SHALL then set s = 0 if relu_en and s < 0.
REQ-025 FINISH SHALL then saturate s to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-026 FINISH SHALL register result and sat, pulse done for one cycle, and return to IDLE.
REQ-027 Latency: with the start-acceptance edge as E0, done and the new result SHALL be visible after edge E(BEATS+1).
REQ-028 busy SHALL be high from after E0 until after E(BEATS+1), when it falls together with done rising.
REQ-029 result and sat SHALL hold their values until the next FINISH.
REQ-030 A start asserted during the done cycle SHALL be accepted (back-to-back operation, no dead cycle).
REQ-031 The accumulator SHALL never overflow, because ACC_W is sized to the worst case.

Reset
REQ-032 rstN=0 SHALL asynchronously force state IDLE and result=0, done=0, busy=0, sat=0, and clear the accumulator and counter.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-034 After rstN rises, the block SHALL accept start on the first clock edge.

Verification (INPUT_SIZE=16, LANES=4, FRAC_BITS=8, DATA_W=16 unless stated)
REQ-035 Unity: all inputs=256, weights=256, bias=0, relu_en=0 -> result=4096, sat=0, done after edge E5.
REQ-036 Saturation: all inputs=weights=32767, bias=0 -> result=32767, sat=1; all inputs=-32768, weights=32767 -> result=-32768, sat=1.
REQ-037 ReLU: all inputs=-256, weights=256, bias=0 -> result=-4096 with relu_en=0, and result=0, sat=0 with relu_en=1.
REQ-038 Floor and bias: inputs[0]=-1, weights[0]=1, others 0, bias=0 -> result=-1; same with bias=5 -> result=4.
REQ-039 Remainder: INPUT_SIZE=10, LANES=4, all pairs=256/256 -> result=2560 with done after edge E4; LANES=1 -> done after edge E11.
REQ-040 Control: start pulsed in MAC is ignored (result unchanged, single done); start in the done cycle gives back-to-back done pulses 6 cycles apart; rstN low in MAC aborts the operation with no done and result=0.
